// File: rtl/spine_pkg.sv
// Shared definitions for the spine router: header field widths, route result
// and arbiter pick types, plus the route decode and round-robin pick helpers.
package spine_pkg;

  localparam int DG_W   = 4;   // dest-group field, at the top of the flit
  localparam int DL_W   = 2;   // dest-leaf field, directly below dest-group
  localparam int MAX_NP = 32;  // widest port count the pick helper handles
  localparam int PORT_W = 8;

  typedef struct packed {
    logic              vld;
    logic [PORT_W-1:0] port;
  } route_t;

  typedef struct packed {
    logic              found;
    logic [PORT_W-1:0] idx;
  } pick_t;

  // Map a header to an output port. Other groups are packed densely after the
  // leaf ports in ascending order, skipping our own group number.
  function automatic route_t route_port(input logic [DG_W-1:0] dg,
                                        input logic [DL_W-1:0] dl,
                                        input int gid, input int nleaf,
                                        input int ngroup);
    route_t r;
    int     g;
    int     p;
    r = '0;
    p = 0;
    g = int'(dg);
    if (g == gid) begin
      r.vld = (int'(dl) < nleaf);
      p     = int'(dl);
    end else if (g >= 1 && g <= ngroup + 1) begin
      r.vld = 1'b1;
      p     = nleaf + ((g < gid) ? g - 1 : g - 2);
    end
    r.port = PORT_W'(p);
    return r;
  endfunction

  // First set bit of req at or after ptr, wrapping at np.
  function automatic pick_t rr_pick(input logic [MAX_NP-1:0] req,
                                    input int ptr, input int np);
    pick_t r;
    int    idx;
    r = '0;
    for (int i = 0; i < MAX_NP; i++) begin
      if (i < np) begin
        idx = ptr + i;
        if (idx >= np) idx = idx - np;
        if (!r.found && req[idx]) begin
          r.found = 1'b1;
          r.idx   = PORT_W'(idx);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/spine_in_fifo.sv
// Per-port input FIFO.
//  clk/reset        clock, async active-high reset (empties the FIFO)
//  push/wdata       write request and flit
//  pop              advance the head (ignored when empty)
//  full/empty/head  registered occupancy flags and head flit
//  ovf              push requested while full
module spine_in_fifo #(
  parameter int DWIDTH     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DWIDTH-1:0] head,
  output logic              ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);

  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]       wptr, rptr;
  logic [DWIDTH-1:0] mem [FIFO_DEPTH];

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];
  assign ovf   = push & full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/spine_router_rr.sv
// Spine router: NUM_LEAF leaf ports plus NUM_GROUP inter-group ports, each with
// an input FIFO, header-based route decode and a round-robin arbiter feeding a
// ready/valid output register per output.
//  clk, reset            clock, async active-high reset
//  in_data/valid/ready   per-port input flits (port p at [p*DWIDTH +: DWIDTH])
//  out_data/valid/ready  per-port routed output flits
//  drop_cnt              saturating count of unroutable flits
//  fifo_ovf              sticky push-while-full indication
module spine_router_rr
  import spine_pkg::*;
#(
  parameter int GROUP_ID   = 1,
  parameter int NUM_LEAF   = 4,
  parameter int NUM_GROUP  = 7,
  parameter int DWIDTH     = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int NP        = NUM_LEAF + NUM_GROUP
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NP*DWIDTH-1:0] in_data,
  input  logic [NP-1:0]        in_valid,
  output logic [NP-1:0]        in_ready,
  output logic [NP*DWIDTH-1:0] out_data,
  output logic [NP-1:0]        out_valid,
  input  logic [NP-1:0]        out_ready,
  output logic [15:0]          drop_cnt,
  output logic                 fifo_ovf
);
  localparam int PW = $clog2(NP);

  logic [NP-1:0]             full, empty, push, pop, drop, ovf;
  logic [NP-1:0][DWIDTH-1:0] head;
  logic [NP-1:0][NP-1:0]     gnt;   // gnt[o][p]: output o takes input p
  route_t                    rt [NP];

  // No bypass: ready is purely from registered occupancy.
  assign in_ready = ~full;
  assign push     = in_valid & ~full;

  for (genvar p = 0; p < NP; p++) begin : g_in
    spine_in_fifo #(.DWIDTH(DWIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[p]),
      .wdata (in_data[p*DWIDTH +: DWIDTH]),
      .pop   (pop[p]),
      .full  (full[p]),
      .empty (empty[p]),
      .head  (head[p]),
      .ovf   (ovf[p])
    );

    assign rt[p]   = route_port(head[p][DWIDTH-1 -: DG_W],
                                head[p][DWIDTH-1-DG_W -: DL_W],
                                GROUP_ID, NUM_LEAF, NUM_GROUP);
    // Unroutable heads are discarded without ever requesting an output.
    assign drop[p] = !empty[p] && !rt[p].vld;
  end

  for (genvar o = 0; o < NP; o++) begin : g_out
    logic [NP-1:0]     req;
    logic [PW-1:0]     ptr;
    logic              slot_free;
    logic              vld_q;
    logic [DWIDTH-1:0] data_q;
    pick_t             pk;

    always_comb begin
      req = '0;
      for (int p = 0; p < NP; p++)
        req[p] = !empty[p] && rt[p].vld && (rt[p].port == PORT_W'(o));
    end

    assign slot_free = !vld_q || out_ready[o];
    assign pk        = rr_pick(MAX_NP'(req), int'(ptr), NP);
    assign gnt[o]    = (slot_free && pk.found) ? (NP'(1) << pk.idx) : '0;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ptr    <= '0;
        vld_q  <= 1'b0;
        data_q <= '0;
      end else if (slot_free) begin
        if (pk.found) begin
          data_q <= head[pk.idx[PW-1:0]];
          vld_q  <= 1'b1;
          ptr    <= (pk.idx == PORT_W'(NP-1)) ? '0 : pk.idx[PW-1:0] + 1'b1;
        end else begin
          vld_q  <= 1'b0;
        end
      end
    end

    assign out_valid[o]                  = vld_q;
    assign out_data[o*DWIDTH +: DWIDTH]  = data_q;
  end

  // Each head requests one output, so grants never overlap across outputs.
  always_comb begin
    pop = drop;
    for (int o = 0; o < NP; o++) pop = pop | gnt[o];
  end

  logic [PW:0] ndrop;
  logic [16:0] drop_sum;

  always_comb begin
    ndrop = '0;
    for (int p = 0; p < NP; p++) ndrop = ndrop + (PW+1)'(drop[p]);
  end

  assign drop_sum = {1'b0, drop_cnt} + 17'(ndrop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
      fifo_ovf <= 1'b0;
    end else begin
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (|ovf) fifo_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spine_router_rr.sv
module tb_spine_router_rr;
  localparam int NL = 4, NG = 7, DW = 16, FD = 8;
  localparam int NP = NL + NG;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NP*DW-1:0]     in_data;
  logic [NP-1:0]        in_valid, in_ready, out_valid, out_ready;
  logic [NP*DW-1:0]     out_data;
  logic [15:0]          drop_cnt;
  logic                 fifo_ovf;

  int                   nerr = 0;
  int                   nchk = 0;
  int                   mon  = 0;
  int                   rcv  = 0;
  logic [DW-1:0]        expq [$];

  always #5 clk = ~clk;

  spine_router_rr #(.GROUP_ID(1), .NUM_LEAF(NL), .NUM_GROUP(NG),
                    .DWIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt),
    .fifo_ovf  (fifo_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int p, input logic [DW-1:0] d);
    in_data[p*DW +: DW] = d;
  endtask

  // Advance one cycle and score whatever the monitored output presents.
  task automatic tick_mon();
    logic [DW-1:0] e;
    tick();
    if (out_valid[mon]) begin
      nchk++;
      assert (expq.size() != 0) else begin
        nerr++;
        $error("FAIL spurious_out port %0d: got %0h want none", mon, out_data[mon*DW +: DW]);
      end
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("out_data_order", 32'(out_data[mon*DW +: DW]), 32'(e));
        rcv++;
      end
    end
  endtask

  task automatic route_case(input string tag, input int p, input logic [DW-1:0] d, input int op);
    logic [NP-1:0] ev;
    ev = '0;
    ev[op] = 1'b1;
    put(p, d);
    in_valid[p] = 1'b1;
    tick();
    in_valid[p] = 1'b0;
    tick();
    chk({tag, "_vld"}, 32'(out_valid), 32'(ev));
    chk({tag, "_data"}, 32'(out_data[op*DW +: DW]), 32'(d));
    tick();
    chk({tag, "_clear"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int  idx;
    int  pp;
    bit  acc;
    bit  sent;
    logic [DW-1:0] f [10];

    reset     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'h7FF);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_fifo_ovf", 32'(fifo_ovf), 32'd0);
    chk("rst_out_data", 32'(|out_data), 32'd0);
    reset = 1'b0;
    tick();

    // Local leaf route, then inter-group routes.
    route_case("leaf2", 0, 16'h1955, 2);
    chk("t1_drop_cnt", 32'(drop_cnt), 32'd0);
    route_case("dg3", 0, 16'h30AB, 5);
    route_case("dg8", 0, 16'h8123, 10);

    // dg=0 and dg=9 are unroutable.
    put(0, 16'h0111); in_valid[0] = 1'b1; tick(); in_valid[0] = 1'b0; tick();
    chk("drop_dg0_cnt", 32'(drop_cnt), 32'd1);
    chk("drop_dg0_vld", 32'(out_valid), 32'd0);
    put(0, 16'h9222); in_valid[0] = 1'b1; tick(); in_valid[0] = 1'b0; tick();
    chk("drop_dg9_cnt", 32'(drop_cnt), 32'd2);
    chk("drop_dg9_vld", 32'(out_valid), 32'd0);

    // Three inputs contend for leaf 3: grants rotate 0,4,7.
    mon = 3; rcv = 0; expq.delete();
    for (int k = 0; k < 18; k++) begin
      pp = (k % 3 == 0) ? 0 : (k % 3 == 1) ? 4 : 7;
      expq.push_back({4'd1, 2'd3, 4'(pp), 6'(k / 3)});
    end
    for (int i = 0; i < 6; i++) begin
      put(0, {4'd1, 2'd3, 4'd0, 6'(i)});
      put(4, {4'd1, 2'd3, 4'd4, 6'(i)});
      put(7, {4'd1, 2'd3, 4'd7, 6'(i)});
      in_valid = 11'b000_1001_0001;
      tick_mon();
    end
    in_valid = '0;
    for (int c = 0; c < 40 && rcv < 18; c++) tick_mon();
    chk("rr_count", 32'(rcv), 32'd18);

    // Back-pressure on leaf 1 until port 2 fills its FIFO.
    for (int i = 0; i < 10; i++) f[i] = {4'd1, 2'd1, 10'(16'h40 + i)};
    out_ready[1] = 1'b0;
    idx = 0;
    for (int c = 0; c < 30 && idx < 9; c++) begin
      put(2, f[idx]);
      in_valid[2] = 1'b1;
      acc = in_ready[2];
      tick();
      if (acc) idx++;
    end
    put(2, f[9]);
    chk("bp_accepted", 32'(idx), 32'd9);
    chk("bp_full_ready", 32'(in_ready[2]), 32'd0);
    chk("bp_out_vld", 32'(out_valid[1]), 32'd1);
    chk("bp_out_data", 32'(out_data[1*DW +: DW]), 32'(f[0]));
    tick();
    chk("stall_ready", 32'(in_ready[2]), 32'd0);
    chk("stall_data", 32'(out_data[1*DW +: DW]), 32'(f[0]));

    // Release: the pop on this edge must not open in_ready in the same cycle.
    out_ready[1] = 1'b1;
    chk("no_bypass_ready", 32'(in_ready[2]), 32'd0);
    mon = 1; rcv = 0; expq.delete(); sent = 1'b0;
    for (int i = 1; i < 10; i++) expq.push_back(f[i]);
    for (int c = 0; c < 40 && rcv < 9; c++) begin
      acc = in_ready[2] && !sent;
      tick_mon();
      if (acc) begin
        in_valid[2] = 1'b0;
        sent = 1'b1;
      end
    end
    in_valid[2] = 1'b0;
    chk("bp_drain_count", 32'(rcv), 32'd9);
    chk("bp_tenth_sent", 32'(sent), 32'd1);

    // Pointer wrap: 3*FIFO_DEPTH flits through port 6 to leaf 0.
    mon = 0; rcv = 0; expq.delete(); idx = 0;
    for (int i = 0; i < 3 * FD; i++) expq.push_back({4'd1, 2'd0, 10'(16'h80 + i)});
    for (int c = 0; c < 80 && (idx < 3 * FD || rcv < 3 * FD); c++) begin
      if (idx < 3 * FD) begin
        put(6, {4'd1, 2'd0, 10'(16'h80 + idx)});
        in_valid[6] = 1'b1;
      end else begin
        in_valid[6] = 1'b0;
      end
      acc = in_ready[6] && (idx < 3 * FD);
      tick_mon();
      if (acc) idx++;
    end
    in_valid[6] = 1'b0;
    chk("wrap_sent", 32'(idx), 32'd24);
    chk("wrap_count", 32'(rcv), 32'd24);

    // Async reset in the middle of a stalled stream.
    out_ready[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put(1, 16'h1900 + 16'(i));
      in_valid[1] = 1'b1;
      tick();
    end
    in_valid[1] = 1'b0;
    chk("pre_rst_vld", 32'(out_valid[2]), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'h7FF);
    chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
    chk("mid_rst_data", 32'(|out_data), 32'd0);
    #2 reset = 1'b0;
    tick();
    out_ready[2] = 1'b1;
    mon = 2; rcv = 0; expq.delete();
    expq.push_back(16'h1A00);
    expq.push_back(16'h1A01);
    for (int i = 0; i < 2; i++) begin
      put(1, 16'h1A00 + 16'(i));
      in_valid[1] = 1'b1;
      tick_mon();
    end
    in_valid[1] = 1'b0;
    for (int c = 0; c < 12; c++) tick_mon();
    chk("post_rst_count", 32'(rcv), 32'd2);
    chk("end_fifo_ovf", 32'(fifo_ovf), 32'd0);
    chk("end_drop_cnt", 32'(drop_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
